// File: rtl/vslc_pkg.sv
// Shared board-level constants for the VSLC input front end.
package vslc_pkg;

  localparam int VSLC_IO_W        = 8;
  localparam int VSLC_CLK_HZ      = 12_000_000;
  localparam int VSLC_DEBOUNCE_MS = 10;

  function automatic int ms_to_cycles(input int clk_hz, input int ms);
    return (clk_hz / 1000) * ms;
  endfunction

  localparam int VSLC_DEBOUNCE_CYCLES = ms_to_cycles(VSLC_CLK_HZ, VSLC_DEBOUNCE_MS);

endpackage

// File: rtl/vslc_input_conditioner_if.sv
// Pin-side / core-side bundle of the input conditioner.
// scan_strobe exists only when VSLC_COND_SCAN_LATCH_EN is defined.
interface vslc_input_conditioner_if
  import vslc_pkg::*;
#(
  parameter int WIDTH = VSLC_IO_W
);
  logic [WIDTH-1:0] raw_in;
  logic [WIDTH-1:0] clean;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
`ifdef VSLC_COND_SCAN_LATCH_EN
  logic             scan_strobe;

  modport master (output raw_in, output scan_strobe, input clean, input rise, input fall);
  modport slave  (input raw_in, input scan_strobe, output clean, output rise, output fall);
`else
  modport master (output raw_in, input clean, input rise, input fall);
  modport slave  (input raw_in, output clean, output rise, output fall);
`endif
endinterface

// File: rtl/vslc_debounce_bit.sv
// One conditioned bit: 2-flop synchroniser, persistence counter, accepted level
// and registered one-cycle rise/fall pulses.
module vslc_debounce_bit
  import vslc_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = VSLC_DEBOUNCE_CYCLES
) (
  input  logic CLK,
  input  logic rst_n,
  input  logic din,
  output logic stable,
  output logic rise,
  output logic fall
);
  localparam int            CW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          s1;
  logic          s2;
  logic [CW-1:0] cnt;

  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      cnt    <= '0;
      stable <= 1'b0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      s1   <= din;
      s2   <= s1;
      rise <= 1'b0;
      fall <= 1'b0;
      // Any sample matching the accepted level restarts the persistence window.
      if (s2 == stable) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        stable <= s2;
        cnt    <= '0;
        rise   <= s2;
        fall   <= ~s2;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/vslc_input_conditioner.sv
// Board input front end: polarity normalise, sync, debounce, edge pulses per bit.
// Optional VSLC_COND_SCAN_LATCH_EN latches a PLC-style input image on scan_strobe.
module vslc_input_conditioner
  import vslc_pkg::*;
#(
  parameter int               WIDTH           = VSLC_IO_W,
  parameter int               DEBOUNCE_CYCLES = VSLC_DEBOUNCE_CYCLES,
  parameter logic [WIDTH-1:0] INVERT_MASK     = WIDTH'(8'h01)
) (
  input  logic                     CLK,
  input  logic                     rst_n,
  vslc_input_conditioner_if.slave  bus
);
  logic [WIDTH-1:0] norm;
  logic [WIDTH-1:0] stable_w;
  logic [WIDTH-1:0] ev_rise;
  logic [WIDTH-1:0] ev_fall;

  assign norm = bus.raw_in ^ INVERT_MASK;

  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    vslc_debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_bit (
      .CLK    (CLK),
      .rst_n  (rst_n),
      .din    (norm[g]),
      .stable (stable_w[g]),
      .rise   (ev_rise[g]),
      .fall   (ev_fall[g])
    );
  end

`ifdef VSLC_COND_SCAN_LATCH_EN
  logic [WIDTH-1:0] clean_q;
  logic [WIDTH-1:0] rise_q;
  logic [WIDTH-1:0] fall_q;
  logic [WIDTH-1:0] pend_rise;
  logic [WIDTH-1:0] pend_fall;

  // Edges between strobes are kept sticky so the next scan image sees them.
  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      clean_q   <= '0;
      rise_q    <= '0;
      fall_q    <= '0;
      pend_rise <= '0;
      pend_fall <= '0;
    end else if (bus.scan_strobe) begin
      clean_q   <= stable_w;
      rise_q    <= pend_rise | ev_rise;
      fall_q    <= pend_fall | ev_fall;
      pend_rise <= '0;
      pend_fall <= '0;
    end else begin
      pend_rise <= pend_rise | ev_rise;
      pend_fall <= pend_fall | ev_fall;
    end
  end

  assign bus.clean = clean_q;
  assign bus.rise  = rise_q;
  assign bus.fall  = fall_q;
`else
  assign bus.clean = stable_w;
  assign bus.rise  = ev_rise;
  assign bus.fall  = ev_fall;
`endif

endmodule

// File: doc/vslc_input_conditioner.md
Name: vslc_input_conditioner

Overview:
Board-side input front end for the VSLC core, feeding the core's ui_in from raw, asynchronous board pins (buttons, PMOD inputs). Per bit, it normalises polarity, synchronises into CLK, debounces, and emits one-cycle rise/fall pulses. The top-level board wrapper instantiates it between the pins and core ui_in.

Parameters:
WIDTH, 8, number of conditioned input bits (matches ui_in width)
DEBOUNCE_CYCLES, 120000, consecutive CLK cycles a new level must persist before acceptance (10 ms at 12 MHz); legal range >= 1
INVERT_MASK, 8'h01, per-bit polarity inversion applied before synchronisation (bit 0 = active-low BTN_N)

Ports:
CLK  in  1  system clock
rst_n  in  1  reset, synchronous, active-low
raw_in  in  WIDTH  asynchronous pin levels
clean  out  WIDTH  debounced, active-high levels to core ui_in
rise  out  WIDTH  one-cycle pulse when clean bit goes 0->1
fall  out  WIDTH  one-cycle pulse when clean bit goes 1->0
scan_strobe  in  1  scan-cycle boundary pulse (present only with VSLC_COND_SCAN_LATCH_EN)

Behaviour:
- One clock, CLK. Reset is synchronous and active-low (rst_n); all state changes on posedge CLK.
- Normalise: n = raw_in ^ INVERT_MASK (combinational, before first flop).
- Sync: 2-flop chain per bit (s1, s2). Reset value 0.
- Debounce per bit: stable bit (reset 0), counter of width $clog2(DEBOUNCE_CYCLES+1) (reset 0).
  - s2 == stable: counter <= 0.
  - s2 != stable and counter < DEBOUNCE_CYCLES-1: counter++.
  - s2 != stable and counter == DEBOUNCE_CYCLES-1: stable <= s2, counter <= 0, rise/fall pulse registered in the same edge.
  - Counter never exceeds DEBOUNCE_CYCLES-1. No wrap.
- Latency: a level first sampled into s1 at edge 0 is visible on clean after edge DEBOUNCE_CYCLES+1. rise/fall assert in exactly that cycle, for 1 cycle.
- Glitch: any return to the stable level before acceptance clears the counter. No output change, no pulse.
- Bits are fully independent. Simultaneous acceptances on several bits give simultaneous pulses.
- Reset values: clean=0, rise=0, fall=0, all counters 0.
- Reset mid-count discards progress. After reset, a held-asserted input produces a rise after the full latency. Inputs idle per INVERT_MASK produce no pulse.
- rise and fall are never both 1 on the same bit in the same cycle.

Optional Feature:
VSLC_COND_SCAN_LATCH_EN
- Defined: adds the scan_strobe port and PLC-style input-image semantics.
  - clean <= stable only in cycles with scan_strobe=1. Otherwise clean holds.
  - Edge events accumulate in sticky pending registers (reset 0).
  - On scan_strobe: rise <= pend_rise | event_now, fall <= pend_fall | event_now, and pending clears.
  - rise/fall then hold until the next strobe, so no edge is lost between scans.
  - A press and release inside one scan report both rise=1 and fall=1, with clean at the final level.
- Undefined: no scan_strobe port. clean, rise and fall behave as in Behaviour.

Decomposition:
- vslc_pkg holds:
  - VSLC_IO_W=8
  - VSLC_CLK_HZ=12_000_000
  - VSLC_DEBOUNCE_MS=10
  - derived default cycle count
- Sub-module vslc_debounce_bit (sync chain, counter, stable bit, pulse flops) is instantiated WIDTH times via generate.
- Polarity mask and scan latch live in the parent.

Test Plan:
Common setup: DEBOUNCE_CYCLES=4, INVERT_MASK=8'h01, latency 6 cycles.
1. Reset: raw_in=8'hFF with rst_n=0 for 3 cycles -> all outputs 0. After release, clean=8'hFE and rise=8'hFE at cycle 6, one cycle only. Bit 0 stays 0.
2. Press/release: raw_in[1] 0->1 held -> clean[1]=1 with rise[1]=1 at cycle 6. Drop to 0 -> fall[1]=1 six cycles later, clean[1]=0.
3. Glitch: raw_in[2] high 3 cycles -> no clean change, no pulse. High 4 cycles -> accepted at cycle 6.
4. Multi-bit: raw_in[5] and raw_in[6] rise on the same edge -> both pulse together. Bit 6 glitch at counter=3 -> only bit 5 accepted.
5. Reset mid-count: raw_in[3] high, rst_n=0 when counter=2 -> clean[3] stays 0. After release a full 6 cycles is required.
6. With VSLC_COND_SCAN_LATCH_EN: press bit 4 accepted 10 cycles before strobe -> clean[4] stays 0 until strobe, then clean[4]=1, rise[4]=1 held until next strobe. Press+release between strobes -> rise[4]=fall[4]=1, clean[4]=0.
